// File: rtl/cp0_exc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc_unit_if
//  Purpose  : Bundles the EX-stage trap inputs, the interrupt lines, the
//             MTC0/MFC0 access bus and the redirect/flush outputs of
//             cp0_exc_unit.
//  Modports : master - pipeline side (drives EX/CP0 inputs, sees outputs)
//             slave  - exception unit side
//  Revision : 1.0 - initial release
// ============================================================================
interface cp0_exc_unit_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_in_ds;
  logic        ex_overflow;
  logic        ex_ov_en;
  logic        ex_syscall;
  logic        ex_eret;
  logic [5:0]  int_hw;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic        exc_redirect;
  logic [31:0] exc_target;

  modport master (
    output ex_valid, ex_pc, ex_in_ds, ex_overflow, ex_ov_en, ex_syscall,
           ex_eret, int_hw, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, exc_flush, exc_redirect, exc_target
  );

  modport slave (
    input  ex_valid, ex_pc, ex_in_ds, ex_overflow, ex_ov_en, ex_syscall,
           ex_eret, int_hw, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, exc_flush, exc_redirect, exc_target
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc_unit
//  Purpose  : CP0 exception receiver. Holds Status/Cause/EPC, priority-selects
//             interrupt > overflow > syscall (ERET lowest, not an exception),
//             and issues a one-cycle PC redirect plus a FLUSH_CYCLES-long
//             pipeline flush.
//  Ports    : clk, rst_n (async, active low)
//             bus (cp0_exc_unit_if.slave): ex_* trap inputs, int_hw[5:0],
//             cp0_we/cp0_addr/cp0_wdata MTC0 bus, cp0_rdata MFC0 data,
//             exc_flush, exc_redirect, exc_target
//  Params   : EXC_VECTOR   - redirect target for every exception
//             FLUSH_CYCLES - exc_flush length per redirect (1..7)
//  Options  : CP0_TIMER_EN - adds Count(9)/Compare(11); Count==Compare sets a
//             sticky IP[15] in place of int_hw[5].
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  cp0_exc_unit_if.slave   bus
);

  localparam logic [2:0] c_flush_last = 3'(FLUSH_CYCLES - 1);
  localparam logic [4:0] c_code_int   = 5'd0;
  localparam logic [4:0] c_code_sys   = 5'd8;
  localparam logic [4:0] c_code_ov    = 5'd12;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;

  // CP0 register fields
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [6:0]  r_ip_lo;    // IP[14:8]
  logic        r_ip7;      // IP[15]
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic        r_redirect;
  logic [31:0] r_target;

  logic [7:0]  w_ip;
  logic        w_idle;
  logic        w_sel;
  logic        w_int_req;
  logic        w_ov_req;
  logic        w_take_int;
  logic        w_take_ov;
  logic        w_take_sys;
  logic        w_take;
  logic        w_eret_go;
  logic        w_event;
  logic [4:0]  w_code;
  logic [31:0] w_epc_cand;
  logic        w_cp0_wr;

  assign w_ip      = {r_ip7, r_ip_lo};
  assign w_idle    = (r_state == S_IDLE);
  // In FLUSH the EX instruction is being squashed, so nothing is sampled.
  assign w_sel     = w_idle & bus.ex_valid;
  assign w_int_req = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign w_ov_req  = bus.ex_overflow & bus.ex_ov_en;

  assign w_take_int = w_sel & w_int_req;
  assign w_take_ov  = w_sel & ~w_int_req & w_ov_req;
  assign w_take_sys = w_sel & ~w_int_req & ~w_ov_req & bus.ex_syscall;
  assign w_take     = w_take_int | w_take_ov | w_take_sys;
  assign w_eret_go  = w_sel & ~w_int_req & ~w_ov_req & ~bus.ex_syscall & bus.ex_eret;
  assign w_event    = w_take | w_eret_go;

  always_comb begin
    w_code = c_code_sys;
    if (w_take_int)     w_code = c_code_int;
    else if (w_take_ov) w_code = c_code_ov;
  end

  // Delay-slot instructions restart at the branch; subtraction wraps mod 2^32.
  assign w_epc_cand = bus.ex_in_ds ? (bus.ex_pc - 32'd4) : bus.ex_pc;

  // A trap/ERET in the same cycle, or any write during FLUSH, drops the MTC0.
  assign w_cp0_wr = bus.cp0_we & w_idle & ~w_event;

  // --------------------------------------------------------------------------
  // Redirect FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_event) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = c_flush_last;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 3'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Status / Cause / EPC
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im      <= 8'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip_lo   <= 7'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip_lo[6:2] <= bus.int_hw[4:0];
      if (w_take) begin
        r_exccode <= w_code;
        r_exl     <= 1'b1;
        // Nested exceptions keep the outermost return point.
        if (!r_exl) begin
          r_epc <= w_epc_cand;
          r_bd  <= bus.ex_in_ds;
        end
      end else if (w_eret_go) begin
        r_exl <= 1'b0;
      end else if (w_cp0_wr) begin
        case (bus.cp0_addr)
          5'd12: begin
            r_im  <= bus.cp0_wdata[15:8];
            r_exl <= bus.cp0_wdata[1];
            r_ie  <= bus.cp0_wdata[0];
          end
          5'd13:   r_ip_lo[1:0] <= bus.cp0_wdata[9:8];
          5'd14:   r_epc        <= bus.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // IP[15] source: timer match or int_hw[5]
  // --------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        w_unused_hw5;

  assign w_unused_hw5 = bus.int_hw[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ip7     <= 1'b0;
    end else begin
      if (w_cp0_wr && bus.cp0_addr == 5'd9) r_count <= bus.cp0_wdata;
      else                                   r_count <= r_count + 32'd1;
      // Writing Compare acknowledges the timer interrupt.
      if (w_cp0_wr && bus.cp0_addr == 5'd11) begin
        r_compare <= bus.cp0_wdata;
        r_ip7     <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ip7 <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ip7 <= 1'b0;
    else        r_ip7 <= bus.int_hw[5];
  end
`endif

  // --------------------------------------------------------------------------
  // Redirect outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect <= 1'b0;
      r_target   <= 32'd0;
    end else begin
      r_redirect <= w_event;
      if (w_event) r_target <= w_take ? EXC_VECTOR : r_epc;
    end
  end

  assign bus.exc_flush    = (r_state == S_FLUSH);
  assign bus.exc_redirect = r_redirect;
  assign bus.exc_target   = r_target;

  // --------------------------------------------------------------------------
  // MFC0 read mux
  // --------------------------------------------------------------------------
  always_comb begin
    bus.cp0_rdata = 32'd0;
    case (bus.cp0_addr)
`ifdef CP0_TIMER_EN
      5'd9:  bus.cp0_rdata = r_count;
      5'd11: bus.cp0_rdata = r_compare;
`endif
      5'd12: bus.cp0_rdata = {16'd0, r_im, 6'd0, r_exl, r_ie};
      5'd13: bus.cp0_rdata = {r_bd, 15'd0, w_ip, 1'b0, r_exccode, 2'b00};
      5'd14: bus.cp0_rdata = r_epc;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
